// File: rtl/mxm_sched_if.sv
// rtl/mxm_sched_if.sv - host start/done and operand/result RAM signals of the MxM sequencer
interface mxm_sched_if #(
  parameter int M = 200,
  parameter int N = 100,
  parameter int P = 120
);
  localparam int AWA = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int AWX = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int AWY = (M * P > 1) ? $clog2(M * P) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AWA-1:0] a_addr;
  logic [AWX-1:0] x_addr;
  logic           dp_first;
  logic           dp_last;
  logic           y_we;
  logic [AWY-1:0] y_addr;

  modport master (
    output start,
    input  busy, done, rd_en, a_addr, x_addr, dp_first, dp_last, y_we, y_addr
  );

  modport slave (
    input  start,
    output busy, done, rd_en, a_addr, x_addr, dp_first, dp_last, y_we, y_addr
  );
endinterface

// File: rtl/mxm_sched.sv
// rtl/mxm_sched.sv - index sequencer for the MxM streaming dot-product datapath
// Walks (p,m,n) with n fastest, issuing A/X reads and writing Y at p*M+m.
module mxm_sched #(
  parameter int M   = 200,
  parameter int N   = 100,
  parameter int P   = 120,
  parameter int LAT = 1
) (
  input logic        i_clk,
  input logic        i_rst,
  mxm_sched_if.slave bus
);
  localparam int AWA = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int AWX = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int AWY = (M * P > 1) ? $clog2(M * P) : 1;
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int MW  = (M > 1) ? $clog2(M) : 1;
  localparam int PW  = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  logic [NW-1:0]  r_n;
  logic [MW-1:0]  r_m;
  logic [PW-1:0]  r_p;
  logic [AWA-1:0] r_a_addr;
  logic [AWX-1:0] r_x_addr;
  logic [AWX-1:0] r_x_base;
  logic [AWY-1:0] r_y_addr;
  logic [AWY-1:0] r_y_cnt;
  logic [LAT-1:0] r_pipe;
  logic           r_busy, r_done, r_rd_en, r_dp_first, r_dp_last, r_y_we, r_y_last;

  logic w_n_wrap, w_m_wrap, w_p_last, w_last_tuple, w_issue_last, w_pipe_out;

  assign w_n_wrap     = (r_n == NW'(N - 1));
  assign w_m_wrap     = (r_m == MW'(M - 1));
  assign w_p_last     = (r_p == PW'(P - 1));
  assign w_last_tuple = w_n_wrap && w_m_wrap && w_p_last;
  assign w_issue_last = r_rd_en && w_n_wrap;
  assign w_pipe_out   = r_pipe[LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_m        <= '0;
      r_p        <= '0;
      r_a_addr   <= '0;
      r_x_addr   <= '0;
      r_x_base   <= '0;
      r_y_addr   <= '0;
      r_y_cnt    <= '0;
      r_pipe     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_dp_first <= 1'b0;
      r_dp_last  <= 1'b0;
      r_y_we     <= 1'b0;
      r_y_last   <= 1'b0;
    end else begin
      // RAM data lands one cycle after issue, so the element flags trail by one
      r_dp_first <= r_rd_en && (r_n == '0);
      r_dp_last  <= w_issue_last;
      r_pipe[0]  <= w_issue_last;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_y_we     <= w_pipe_out;
      r_y_last   <= w_pipe_out && (r_y_cnt == AWY'(M * P - 1));
      if (w_pipe_out) begin
        r_y_addr <= r_y_cnt;
        r_y_cnt  <= r_y_cnt + 1'b1;
      end
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_y_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_last_tuple) begin
            r_state  <= S_DRAIN;
            r_rd_en  <= 1'b0;
            r_n      <= '0;
            r_m      <= '0;
            r_p      <= '0;
            r_a_addr <= '0;
            r_x_addr <= '0;
            r_x_base <= '0;
          end else begin
            r_n      <= w_n_wrap ? '0 : r_n + 1'b1;
            r_a_addr <= (w_n_wrap && w_m_wrap) ? '0 : r_a_addr + 1'b1;
            // X is column-major: replay column p for each row, advance on m wrap
            r_x_addr <= (w_n_wrap && !w_m_wrap) ? r_x_base : r_x_addr + 1'b1;
            if (w_n_wrap) r_m <= w_m_wrap ? '0 : r_m + 1'b1;
            if (w_n_wrap && w_m_wrap) begin
              r_p      <= r_p + 1'b1;
              r_x_base <= r_x_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_y_we && r_y_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_y_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_en    = r_rd_en;
  assign bus.a_addr   = r_a_addr;
  assign bus.x_addr   = r_x_addr;
  assign bus.dp_first = r_dp_first;
  assign bus.dp_last  = r_dp_last;
  assign bus.y_we     = r_y_we;
  assign bus.y_addr   = r_y_addr;
endmodule

// File: tb/tb_mxm_sched.sv
// tb/tb_mxm_sched.sv - directed checks of mxm_sched in three configurations
module tb_mxm_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mxm_sched_if #(.M(2), .N(3), .P(2)) ifa ();
  mxm_sched_if #(.M(2), .N(1), .P(2)) ifb ();
  mxm_sched_if #(.M(2), .N(3), .P(2)) ifc ();

  mxm_sched #(.M(2), .N(3), .P(2), .LAT(1)) u_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  mxm_sched #(.M(2), .N(1), .P(2), .LAT(1)) u_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
  mxm_sched #(.M(2), .N(3), .P(2), .LAT(4)) u_c (.i_clk(clk), .i_rst(rst), .bus(ifc));

  typedef struct {
    logic st;
    logic rd;
    int   a;
    int   x;
    logic df;
    logic dl;
    logic we;
    int   ya;
    logic busy;
    logic done;
  } row_t;

  row_t tbl[18];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] pk(logic busy, logic done, logic rd, logic df, logic dl,
                                     logic we, int a, int x, int ya);
    return {4'b0, busy, done, rd, df, dl, we, 2'b0, a[3:0], x[3:0], ya[3:0], 8'b0};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] act_a(logic mask_ya);
    return pk(ifa.busy, ifa.done, ifa.rd_en, ifa.dp_first, ifa.dp_last, ifa.y_we,
              int'(ifa.a_addr), int'(ifa.x_addr), (mask_ya ? int'(ifa.y_addr) : 0));
  endfunction

  initial begin
    int we_cnt;
    int seen_done;
    //           st rd a  x  df dl we ya busy done
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 1, 2, 2, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 3, 0, 0, 1, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 4, 1, 1, 0, 1, 0, 1, 0};
    tbl[6]  = '{1, 1, 5, 2, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 3, 0, 1, 0, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 4, 1, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 1, 2, 5, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 3, 3, 0, 1, 0, 0, 1, 0};
    tbl[11] = '{0, 1, 4, 4, 1, 0, 1, 2, 1, 0};
    tbl[12] = '{0, 1, 5, 5, 0, 0, 0, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", act_a(1'b1), 32'h0);
    chk("reset_b", pk(ifb.busy, ifb.done, ifb.rd_en, ifb.dp_first, ifb.dp_last, ifb.y_we,
                      int'(ifb.a_addr), int'(ifb.x_addr), int'(ifb.y_addr)), 32'h0);
    chk("reset_c", pk(ifc.busy, ifc.done, ifc.rd_en, ifc.dp_first, ifc.dp_last, ifc.y_we,
                      int'(ifc.a_addr), int'(ifc.x_addr), int'(ifc.y_addr)), 32'h0);
    rst = 1'b0;

    // Full run with stray starts mid-run and in DONE
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("runA_cyc%0d", k), act_a(tbl[k].we),
          pk(tbl[k].busy, tbl[k].done, tbl[k].rd, tbl[k].df, tbl[k].dl, tbl[k].we,
             tbl[k].a, tbl[k].x, tbl[k].ya));
      ifa.start = tbl[k].st;
    end
    ifa.start = 1'b0;

    // Reset at cycle 7 aborts the run, pipe included
    @(negedge clk);
    ifa.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ifa.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cyc8", act_a(1'b1), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cyc9", act_a(1'b1), 32'h0);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    chk("fresh_cyc1", act_a(1'b0), pk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("fresh_cyc2", act_a(1'b0), pk(1, 0, 1, 1, 0, 0, 1, 1, 0));
    we_cnt = 0;
    seen_done = 0;
    for (int k = 0; k < 40 && seen_done == 0; k++) begin
      @(negedge clk);
      if (ifa.y_we) we_cnt++;
      if (ifa.done) seen_done = 1;
    end
    chk("fresh_done_seen", 32'(seen_done), 32'd1);
    chk("fresh_we_count", 32'(we_cnt), 32'd4);

    // N=1: results arrive back-to-back
    @(negedge clk);
    ifb.start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      logic rd, fl, we, busy, done;
      int a, x, ya;
      rd   = (k >= 1 && k <= 4);
      fl   = (k >= 2 && k <= 5);
      we   = (k >= 3 && k <= 6);
      busy = (k >= 1 && k <= 6);
      done = (k == 7);
      a    = rd ? ((k - 1) % 2) : 0;
      x    = rd ? ((k - 1) / 2) : 0;
      ya   = we ? (k - 3) : 0;
      if (k > 0) begin
        chk($sformatf("runB_cyc%0d", k),
            pk(ifb.busy, ifb.done, ifb.rd_en, ifb.dp_first, ifb.dp_last, ifb.y_we,
               int'(ifb.a_addr), int'(ifb.x_addr), (we ? int'(ifb.y_addr) : 0)),
            pk(busy, done, rd, fl, fl, we, a, x, ya));
      end
      @(negedge clk);
      ifb.start = 1'b0;
    end

    // LAT=4: same issue pattern as the first run, results four cycles after dp_last
    ifc.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic rd, df, dl, we, busy, done;
      int a, x, ya;
      rd   = (k < 18) ? tbl[k].rd : 1'b0;
      df   = (k < 18) ? tbl[k].df : 1'b0;
      dl   = (k < 18) ? tbl[k].dl : 1'b0;
      a    = (k < 18) ? tbl[k].a : 0;
      x    = (k < 18) ? tbl[k].x : 0;
      we   = (k == 8 || k == 11 || k == 14 || k == 17);
      ya   = we ? (k - 8) / 3 : 0;
      busy = (k >= 1 && k <= 17);
      done = (k == 18);
      chk($sformatf("runC_cyc%0d", k),
          pk(ifc.busy, ifc.done, ifc.rd_en, ifc.dp_first, ifc.dp_last, ifc.y_we,
             int'(ifc.a_addr), int'(ifc.x_addr), (we ? int'(ifc.y_addr) : 0)),
          pk(busy, done, rd, df, dl, we, a, x, ya));
      @(negedge clk);
      ifc.start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
